// File: rtl/shift_left_seq_if.sv
// Start/done handshake and result bus for the sequential left shifter.
// The master drives the request; the slave returns the result and the flags.
interface shift_left_seq_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SHW   = 2
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   b;
  logic [WIDTH-1:0] y;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  y, N, Z, C, V, busy, done
  );

  modport slave (
    input  start, a, b,
    output y, N, Z, C, V, busy, done
  );
endinterface

// File: rtl/shift_left_seq.sv
// Sequential logical shift-left, one bit per clock, with N/Z/C/V flags.
// Define SHIFT_LEFT_SEQ_ROTATE_EN to rotate left instead (V forced to 0).
module shift_left_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SHW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  shift_left_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_y;
  logic [SHW-1:0]   r_cnt;
  logic             r_c;
  logic             r_v;

  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_step_y;
  logic             w_step_c;
  logic             w_step_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = (bus.b == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == SHW'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // One step of the shifter; the MSB leaving the word always becomes C.
  always_comb begin
    w_step_c = r_y[WIDTH-1];
`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
    w_step_y = {r_y[WIDTH-2:0], r_y[WIDTH-1]};
    w_step_v = 1'b0;
`else
    w_step_y = {r_y[WIDTH-2:0], 1'b0};
    w_step_v = r_v | (r_y[WIDTH-1] ^ r_y[WIDTH-2]);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y   <= '0;
      r_cnt <= '0;
      r_c   <= 1'b0;
      r_v   <= 1'b0;
    end else if (w_accept) begin
      r_y   <= bus.a;
      r_cnt <= bus.b;
      r_c   <= 1'b0;
      r_v   <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_y   <= w_step_y;
      r_cnt <= r_cnt - SHW'(1);
      r_c   <= w_step_c;
      r_v   <= w_step_v;
    end
  end

  assign bus.y    = r_y;
  assign bus.N    = r_y[WIDTH-1];
  assign bus.Z    = (r_y == '0);
  assign bus.C    = r_c;
  assign bus.V    = r_v;
  assign bus.busy = w_busy;
  assign bus.done = w_done;

endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard bench for shift_left_seq: stimulus pushes expected results,
// a monitor pops and checks them on every done pulse, including latency.
module tb_shift_left_seq;

  typedef struct {
    logic [3:0]  y;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int unsigned n_tests;
  int unsigned n_fail;
  exp_t        sb[$];

  shift_left_seq_if #(.WIDTH(4), .SHW(2)) bus_if ();

  shift_left_seq #(.WIDTH(4), .SHW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus_if.done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("y",       {28'd0, bus_if.y}, {28'd0, e.y});
        check("N",       {31'd0, bus_if.N}, {31'd0, e.n});
        check("Z",       {31'd0, bus_if.Z}, {31'd0, e.z});
        check("C",       {31'd0, bus_if.C}, {31'd0, e.c});
        check("V",       {31'd0, bus_if.V}, {31'd0, e.v});
        check("busy_at_done", {31'd0, bus_if.busy}, 32'd1);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic run_op(input logic [3:0] a, input logic [1:0] b,
                        input logic [3:0] ey, input logic en, input logic ez,
                        input logic ec, input logic ev);
    exp_t e;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    e.y = ey; e.n = en; e.z = ez; e.c = ec; e.v = ev;
    e.cyc = cyc + 1 + int'(b);
    sb.push_back(e);
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got no done within 20 cycles expected done for a=%b b=%0d", a, b);
      sb.delete();
    end
    repeat (2) @(negedge clk);
    check("hold_y",    {28'd0, bus_if.y},    {28'd0, ey});
    check("hold_C",    {31'd0, bus_if.C},    {31'd0, ec});
    check("hold_V",    {31'd0, bus_if.V},    {31'd0, ev});
    check("idle_busy", {31'd0, bus_if.busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_y",    {28'd0, bus_if.y},    32'd0);
    check("rst_Z",    {31'd0, bus_if.Z},    32'd1);
    check("rst_N",    {31'd0, bus_if.N},    32'd0);
    check("rst_C",    {31'd0, bus_if.C},    32'd0);
    check("rst_V",    {31'd0, bus_if.V},    32'd0);
    check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rst_done", {31'd0, bus_if.done}, 32'd0);
    rst = 1'b0;

    // Reset mid-shift: load on edge 1, one shift on edge 2, then async reset.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = 4'b1111;
    bus_if.b     = 2'd3;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    @(posedge clk);
    #1 check("mid_busy", {31'd0, bus_if.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_y",    {28'd0, bus_if.y},    32'd0);
    check("abort_Z",    {31'd0, bus_if.Z},    32'd1);
    check("abort_C",    {31'd0, bus_if.C},    32'd0);
    check("abort_V",    {31'd0, bus_if.V},    32'd0);
    check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

`ifdef SHIFT_LEFT_SEQ_ROTATE_EN
    run_op(4'b0101, 2'd1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(4'b1001, 2'd2, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'b1110, 2'd3, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(4'b1001, 2'd1, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(4'b1111, 2'd3, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
`else
    run_op(4'b0101, 2'd1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(4'b1001, 2'd2, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(4'b1110, 2'd3, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
    run_op(4'b1111, 2'd3, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    // b=0 op, then a second start while busy (DONE state) must be ignored.
    begin
      exp_t e;
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.a     = 4'b0110;
      bus_if.b     = 2'd0;
      e.y = 4'b0110; e.n = 1'b0; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0;
      e.cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      check("busy_in_done", {31'd0, bus_if.busy}, 32'd1);
      bus_if.start = 1'b1;
      bus_if.a     = 4'b0001;
      bus_if.b     = 2'd2;
      @(negedge clk);
      bus_if.start = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout_b0: got no done expected done for b=0");
        sb.delete();
      end
      repeat (6) @(negedge clk);
      check("ignored_y",    {28'd0, bus_if.y},    32'h6);
      check("ignored_busy", {31'd0, bus_if.busy}, 32'd0);
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
